// File: rtl/qracc_pkg.sv
// Shared types for the QRAcc SRAM interface: sequencer states and the
// bundled pin views used by the parent when binding sram_itf.
package qracc_pkg;

  localparam int SRAM_ROWS = 128;
  localparam int SRAM_COLS = 32;
  localparam int SEQ_CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRECH,
    S_WLON,
    S_SENSE,
    S_DONE
  } sram_seq_state_t;

  typedef struct packed {
    logic [SRAM_ROWS-1:0] wl;
    logic                 pch;
    logic                 write;
    logic [SRAM_COLS-1:0] wr_data;
    logic [SRAM_COLS-1:0] csel;
    logic                 saen;
  } to_sram_t;

  typedef struct packed {
    logic [SRAM_COLS-1:0] sa_out;
  } from_sram_t;

endpackage

// File: rtl/sram_itf_responder.sv
// Slave end of sram_itf: takes one read/write request at a time and sequences
// precharge, wordline and sense phases on the array pins. All pins are flopped.
module sram_itf_responder
  import qracc_pkg::*;
#(
  parameter int numRows    = 128,
  parameter int numCols    = 32,
  parameter int PCH_CYCLES = 2,
  parameter int WL_CYCLES  = 2,
  parameter int SA_CYCLES  = 1,
  localparam int AW        = $clog2(numRows)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               rq_wr_i,
  input  logic               rq_valid_i,
  output logic               rq_ready_o,
  output logic               rd_valid_o,
  output logic [numCols-1:0] rd_data_o,
  input  logic [numCols-1:0] wr_data_i,
  input  logic [AW-1:0]      addr_i,
  output logic [numRows-1:0] WL,
  output logic               PCH,
  output logic               WRITE,
  output logic [numCols-1:0] WR_DATA,
  output logic [numCols-1:0] CSEL,
  output logic               SAEN,
  input  logic [numCols-1:0] SA_OUT
);

  sram_seq_state_t state, state_d;
  logic [SEQ_CNT_W-1:0] cnt, cnt_d;
  logic               wr_q;
  logic [AW-1:0]      addr_q;
  logic [numCols-1:0] data_q;
  logic               in_range;

  logic [numRows-1:0] wl_d;
  logic               write_d;

  // Non-power-of-two arrays can be addressed past the last row.
  assign in_range = (int'(addr_q) < numRows);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      S_IDLE: if (rq_valid_i) begin
        state_d = S_PRECH;
        cnt_d   = SEQ_CNT_W'(PCH_CYCLES - 1);
      end
      S_PRECH: if (cnt == '0) begin
        state_d = S_WLON;
        cnt_d   = SEQ_CNT_W'(WL_CYCLES - 1);
      end else cnt_d = cnt - SEQ_CNT_W'(1);
      S_WLON: if (cnt == '0) begin
        state_d = wr_q ? S_IDLE : S_SENSE;
        cnt_d   = SEQ_CNT_W'(SA_CYCLES - 1);
      end else cnt_d = cnt - SEQ_CNT_W'(1);
      S_SENSE: if (cnt == '0) state_d = S_DONE;
               else cnt_d = cnt - SEQ_CNT_W'(1);
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pin values are derived from the next state so they flop in step with it.
  always_comb begin
    wl_d = '0;
    if (state_d == S_WLON && in_range) wl_d[addr_q] = 1'b1;
    write_d = (state_d == S_WLON) && wr_q && in_range;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rq_ready_o <= 1'b1;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      WL         <= '0;
      PCH        <= 1'b0;
      WRITE      <= 1'b0;
      WR_DATA    <= '0;
      CSEL       <= '0;
      SAEN       <= 1'b0;
    end else begin
      if (state == S_IDLE && rq_valid_i) begin
        wr_q   <= rq_wr_i;
        addr_q <= addr_i;
        data_q <= wr_data_i;
      end
      if (state == S_SENSE && cnt == '0)
        rd_data_o <= in_range ? SA_OUT : '0;
      rq_ready_o <= (state_d == S_IDLE);
      rd_valid_o <= (state_d == S_DONE);
      WL         <= wl_d;
      PCH        <= (state_d == S_PRECH);
      WRITE      <= write_d;
      WR_DATA    <= write_d ? data_q : '0;
      CSEL       <= (state_d == S_WLON) ? '1 : '0;
      SAEN       <= (state_d == S_SENSE);
    end
  end

endmodule
